// File: rtl/grf_operand_fetch_if.sv
// Decode/issue-side bundle between the decoder, the GRF read ports, writeback
// and the operand fetch block.
interface grf_operand_fetch_if #(
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic             id_ready;
  logic [4:0]       id_rs;
  logic             id_rs_use;
  logic [4:0]       id_rt;
  logic             id_rt_use;
  logic [4:0]       id_dst;
  logic             id_dst_we;
  logic [31:0]      grf_rd1;
  logic [31:0]      grf_rd2;
  logic             wb_we;
  logic [4:0]       wb_a3;
  logic [31:0]      wb_wd;
  logic [31:0]      opnd_a;
  logic [31:0]      opnd_b;
  logic [31:0]      busy_vec;
  logic [3:0]       inflight;
  logic [CNT_W-1:0] stall_cnt;
  logic             clr_cnt;
  logic             wb_err;

  modport master (
    output id_valid, id_rs, id_rs_use, id_rt, id_rt_use, id_dst, id_dst_we,
           grf_rd1, grf_rd2, wb_we, wb_a3, wb_wd, clr_cnt,
    input  id_ready, opnd_a, opnd_b, busy_vec, inflight, stall_cnt, wb_err
  );

  modport slave (
    input  id_valid, id_rs, id_rs_use, id_rt, id_rt_use, id_dst, id_dst_we,
           grf_rd1, grf_rd2, wb_we, wb_a3, wb_wd, clr_cnt,
    output id_ready, opnd_a, opnd_b, busy_vec, inflight, stall_cnt, wb_err
  );
endinterface

// File: rtl/grf_operand_fetch.sv
// Operand fetch: per-register write scoreboard, same-cycle writeback forwarding,
// RAW/WAW/in-flight issue blocking and a saturating stall counter.

module grf_opnd_resolve (
  input  logic [4:0]  ra_i,
  input  logic [31:0] rd_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_a3_i,
  input  logic [31:0] wb_wd_i,
  output logic        hit_o,
  output logic [31:0] opnd_o
);
  // GRF writes land at the edge, so a writeback this cycle must be bypassed.
  assign hit_o  = wb_we_i && (wb_a3_i == ra_i) && (ra_i != 5'd0);
  assign opnd_o = (ra_i == 5'd0) ? 32'd0 : (hit_o ? wb_wd_i : rd_i);
endmodule

module grf_operand_fetch #(
  parameter int MAX_INFLIGHT = 8,
  parameter int CNT_W        = 32
) (
  input  logic               clk,
  input  logic               reset,
  grf_operand_fetch_if.slave bus
);
  localparam int NSRC = 2;

  logic [31:0]      busy_q, busy_d;
  logic [3:0]       inflight_q, inflight_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             err_q, err_d;

  logic [NSRC-1:0][4:0]  src;
  logic [NSRC-1:0][31:0] rd, opnd;
  logic [NSRC-1:0]       src_use, hit, raw;

  assign src     = {bus.id_rt, bus.id_rs};
  assign rd      = {bus.grf_rd2, bus.grf_rd1};
  assign src_use = {bus.id_rt_use, bus.id_rs_use};

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    grf_opnd_resolve u_res (
      .ra_i    (src[g]),
      .rd_i    (rd[g]),
      .wb_we_i (bus.wb_we),
      .wb_a3_i (bus.wb_a3),
      .wb_wd_i (bus.wb_wd),
      .hit_o   (hit[g]),
      .opnd_o  (opnd[g])
    );
    assign raw[g] = src_use[g] && busy_q[src[g]] && !hit[g];
  end

  logic wb_nz, wb_clr, wb_bad, dst_nz, dst_hit, waw, full, ready, set;

  assign wb_nz   = bus.wb_we && (bus.wb_a3 != 5'd0);
  assign wb_clr  = wb_nz && busy_q[bus.wb_a3];
  assign wb_bad  = wb_nz && !busy_q[bus.wb_a3];
  assign dst_nz  = bus.id_dst_we && (bus.id_dst != 5'd0);
  assign dst_hit = bus.wb_we && (bus.wb_a3 == bus.id_dst);
  assign waw     = dst_nz && busy_q[bus.id_dst] && !dst_hit;
  // A retiring write frees a slot in the same cycle, so a full window can still issue.
  assign full    = (inflight_q == 4'(MAX_INFLIGHT)) && !wb_clr;
  assign ready   = reset && !(|raw) && !waw && !full;
  assign set     = bus.id_valid && ready && dst_nz;

  always_comb begin
    busy_d     = busy_q;
    inflight_d = inflight_q + 4'(set) - 4'(wb_clr);
    err_d      = err_q | wb_bad;
    stall_d    = stall_q;
    if (wb_clr) busy_d[bus.wb_a3] = 1'b0;
    // Set after clear so a re-issue to the retiring register keeps it busy.
    if (set)    busy_d[bus.id_dst] = 1'b1;
    if (bus.clr_cnt)
      stall_d = '0;
    else if (bus.id_valid && !ready && !(&stall_q))
      stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q     <= '0;
      inflight_q <= '0;
      stall_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      stall_q    <= stall_d;
      err_q      <= err_d;
    end
  end

  assign bus.id_ready  = ready;
  assign bus.opnd_a    = opnd[0];
  assign bus.opnd_b    = opnd[1];
  assign bus.busy_vec  = busy_q;
  assign bus.inflight  = inflight_q;
  assign bus.stall_cnt = stall_q;
  assign bus.wb_err    = err_q;
endmodule

// File: tb/tb_grf_operand_fetch.sv
// Randomized + directed bench for grf_operand_fetch against a behavioural scoreboard model.
module tb_grf_operand_fetch;
  localparam int MAXI  = 8;
  localparam int CNT_W = 6;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  grf_operand_fetch_if #(.CNT_W(CNT_W)) bus();
  grf_operand_fetch #(.MAX_INFLIGHT(MAXI), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: which registers have a pending write, stall count, sticky error.
  bit m_busy [32];
  int m_stall;
  bit m_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < 32; i++) if (m_busy[i]) c++;
    return c;
  endfunction

  function automatic logic [31:0] m_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic bit wbh(input logic [4:0] r);
    return bus.wb_we && bus.wb_a3 == r && r != 0;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
    m_stall = 0;
    m_err   = 0;
  endtask

  task automatic drive(input bit v, input logic [4:0] rs, input bit rsu, input logic [4:0] rt,
                       input bit rtu, input logic [4:0] dst, input bit dwe, input bit we,
                       input logic [4:0] a3, input logic [31:0] wd, input bit clr);
    bus.id_valid = v;   bus.id_rs = rs;   bus.id_rs_use = rsu;
    bus.id_rt = rt;     bus.id_rt_use = rtu;
    bus.id_dst = dst;   bus.id_dst_we = dwe;
    bus.wb_we = we;     bus.wb_a3 = a3;   bus.wb_wd = wd;
    bus.clr_cnt = clr;
    bus.grf_rd1 = $urandom; bus.grf_rd2 = $urandom;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Compare all outputs against the model, clock once, advance the model.
  task automatic tick();
    bit rdy, full, clr_ok;
    logic [31:0] ea, eb;
    #1;
    clr_ok = bus.wb_we && bus.wb_a3 != 0 && m_busy[bus.wb_a3];
    full   = (m_cnt() == MAXI) && !clr_ok;
    rdy    = !(bus.id_rs_use && m_busy[bus.id_rs] && !wbh(bus.id_rs))
          && !(bus.id_rt_use && m_busy[bus.id_rt] && !wbh(bus.id_rt))
          && !(bus.id_dst_we && bus.id_dst != 0 && m_busy[bus.id_dst] && !wbh(bus.id_dst))
          && !full;
    ea = (bus.id_rs == 0) ? 32'd0 : (wbh(bus.id_rs) ? bus.wb_wd : bus.grf_rd1);
    eb = (bus.id_rt == 0) ? 32'd0 : (wbh(bus.id_rt) ? bus.wb_wd : bus.grf_rd2);
    chk("busy_vec",  bus.busy_vec,  m_vec());
    chk("inflight",  bus.inflight,  m_cnt());
    chk("stall_cnt", bus.stall_cnt, m_stall);
    chk("wb_err",    bus.wb_err,    m_err);
    chk("id_ready",  bus.id_ready,  rdy);
    chk("opnd_a",    bus.opnd_a,    ea);
    chk("opnd_b",    bus.opnd_b,    eb);
    if (bus.wb_we && bus.wb_a3 != 0 && !m_busy[bus.wb_a3]) m_err = 1;
    if (clr_ok) m_busy[bus.wb_a3] = 0;
    if (bus.id_valid && rdy && bus.id_dst_we && bus.id_dst != 0) m_busy[bus.id_dst] = 1;
    if (bus.clr_cnt) m_stall = 0;
    else if (bus.id_valid && !rdy && m_stall < SAT) m_stall++;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_busy",  bus.busy_vec,  0);
    chk("rst_infl",  bus.inflight,  0);
    chk("rst_stall", bus.stall_cnt, 0);
    chk("rst_err",   bus.wb_err,    0);
    chk("rst_ready", bus.id_ready,  0);
    m_clear();
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int bq[$];
    logic [4:0] a3;
    m_clear();
    idle();
    bus.id_valid = 1'b1; bus.id_dst = 5'd4; bus.id_dst_we = 1'b1;
    #2;
    chk("init_ready", bus.id_ready, 0);
    chk("init_busy",  bus.busy_vec, 0);
    @(posedge clk); #1;
    chk("init_hold_busy", bus.busy_vec, 0);
    chk("init_hold_infl", bus.inflight, 0);
    reset = 1'b1;

    // Issue to $5, then a dependent read stalls.
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0); tick();
    chk("t1_busy", bus.busy_vec, 32'h20);
    chk("t1_infl", bus.inflight, 1);
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0); tick(); tick(); tick();
    chk("t1_stall", bus.stall_cnt, 3);

    // Writeback forwarding releases the stall in the same cycle.
    drive(1, 5, 1, 0, 0, 0, 0, 1, 5, 32'h1234ABCD, 0);
    #1;
    chk("t2_ready", bus.id_ready, 1);
    chk("t2_opnd_a", bus.opnd_a, 32'h1234ABCD);
    tick();
    chk("t2_busy", bus.busy_vec, 0);
    chk("t2_infl", bus.inflight, 0);

    // Re-issue to a register retiring this cycle: set wins.
    drive(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 8, 1, 1, 8, $urandom, 0);
    #1;
    chk("t3_ready", bus.id_ready, 1);
    tick();
    chk("t3_busy", bus.busy_vec, 32'h100);
    chk("t3_infl", bus.inflight, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 8, $urandom, 0); tick();

    // Fill the in-flight window, then issue while one write retires.
    for (int i = 1; i <= 8; i++) begin
      drive(1, 0, 0, 0, 0, 5'(i), 1, 0, 0, 0, 0); tick();
    end
    chk("t4_infl", bus.inflight, 8);
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0);
    #1;
    chk("t4_full", bus.id_ready, 0);
    tick();
    drive(1, 0, 0, 0, 0, 9, 1, 1, 3, $urandom, 0);
    #1;
    chk("t4_ready", bus.id_ready, 1);
    tick();
    chk("t4_infl2", bus.inflight, 8);
    chk("t4_busy", bus.busy_vec, 32'h3F6);

    // $0 is never forwarded, cleared or flagged.
    drive(0, 0, 1, 0, 1, 0, 0, 1, 0, 32'hFFFFFFFF, 0);
    #1;
    chk("t5_opnd_a", bus.opnd_a, 0);
    tick();
    chk("t5_err", bus.wb_err, 0);
    chk("t5_busy", bus.busy_vec, 32'h3F6);

    // Stall, clear, resume; then saturate.
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); tick(); tick();
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    chk("t6_clr", bus.stall_cnt, 0);
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("t6_resume", bus.stall_cnt, 1);
    for (int i = 0; i < SAT + 8; i++) tick();
    chk("t6_sat", bus.stall_cnt, SAT);

    // Mid-operation reset forgets pending writes; stale writeback flags an error.
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 7, $urandom, 0); tick();
    chk("t7_err", bus.wb_err, 1);
    idle(); tick(); tick();
    chk("t7_sticky", bus.wb_err, 1);
    do_reset();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      bq.delete();
      for (int i = 1; i < 32; i++) if (m_busy[i]) bq.push_back(i);
      a3 = 5'($urandom_range(0, 12));
      if (bq.size() > 0 && $urandom_range(0, 19) != 0)
        a3 = 5'(bq[$urandom_range(0, bq.size() - 1)]);
      drive($urandom_range(0, 3) != 0,
            5'($urandom_range(0, 12)), 1'($urandom), 5'($urandom_range(0, 12)), 1'($urandom),
            5'($urandom_range(0, 12)), $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 5 && (bq.size() > 0 || $urandom_range(0, 9) == 0),
            a3, $urandom, $urandom_range(0, 29) == 0);
      tick();
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
